// File: rtl/iosys_pkg.sv
// iosys_pkg: shared definitions for the iosys memory-side blocks.
//   - Port index constants for the RV memory arbiter (boot, cpu, dma, none).
//   - Arbiter FSM state encoding (IDLE/BUSY/DONE).
//   - Read data substituted when a downstream transfer times out.
//   - port_onehot(): maps a port index to its one-hot ready vector.
package iosys_pkg;

    localparam logic [1:0] PORT_BOOT  = 2'd0;
    localparam logic [1:0] PORT_CPU   = 2'd1;
    localparam logic [1:0] PORT_DMA   = 2'd2;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Index 3 (GRANT_NONE) maps to no ready line at all.
    function automatic logic [2:0] port_onehot(input logic [1:0] p);
        case (p)
            PORT_BOOT: return 3'b001;
            PORT_CPU:  return 3'b010;
            PORT_DMA:  return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin picker.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   req[1:0]     - request lines (req[0] = cpu, req[1] = dma in the arbiter)
//   advance      - the current pick was granted; remember it as last served
//   pick         - index of the chosen request (valid when any = 1)
//   any          - at least one request is present
module arb_rr2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       pick,
    output logic       any
);

    // Last served index. Resets to 1 so req[0] wins the first tie.
    logic last_q;

    assign any = |req;

    always_comb begin
        if (&req) begin
            pick = ~last_q;
        end else begin
            pick = req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else if (advance && any) begin
            last_q <= pick;
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares the 32-bit RV memory port among boot loader (m0),
// picorv32 core (m1) and DMA (m2). Boot has absolute priority between
// transactions; cpu and dma alternate round-robin. One transaction is
// outstanding downstream at a time.
// Ports:
//   clk, resetn                 - clock, synchronous active-low reset
//   mN_valid/addr/wdata/wstrb   - requester N command (wstrb 0 = read)
//   mN_ready/rdata              - one-cycle completion pulse + read data
//   rv_valid/addr/wdata/wstrb   - downstream command (registered)
//   rv_ready/rdata              - downstream completion + read data
//   grant                       - current/last granted port, 3 = none yet
//   timeout_err                 - sticky downstream timeout flag
//   state_o                     - FSM state (IDLE/BUSY/DONE) for observation
// Build option: MEM_ARB_TIMEOUT_EN enables the BUSY-state timeout counter;
// without it BUSY waits for rv_ready indefinitely and timeout_err is 0.
module rv_mem_arbiter
    import iosys_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    input  logic              m2_valid,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [31:0]       m2_wdata,
    input  logic [3:0]        m2_wstrb,
    output logic              m2_ready,
    output logic [31:0]       m2_rdata,
    output logic              rv_valid,
    output logic [ADDR_W-1:0] rv_addr,
    output logic [31:0]       rv_wdata,
    output logic [3:0]        rv_wstrb,
    input  logic              rv_ready,
    input  logic [31:0]       rv_rdata,
    output logic [1:0]        grant,
    output logic              timeout_err,
    output logic [1:0]        state_o
);

    arb_state_e        state_q, state_d;
    logic              rv_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        grant_q;
    logic [2:0]        ready_q;

    logic              start;
    logic [1:0]        sel;
    logic              expire;
    logic              rr_pick, rr_any, rr_advance;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;

    arb_rr2 u_rr (
        .clk     (clk),
        .resetn  (resetn),
        .req     ({m2_valid, m1_valid}),
        .advance (rr_advance),
        .pick    (rr_pick),
        .any     (rr_any)
    );

    // Requests are only looked at in IDLE, so a valid still held during
    // DONE for the transfer just completed cannot be granted twice.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        sel     = PORT_BOOT;
        case (state_q)
            IDLE: begin
                if (m0_valid) begin
                    start = 1'b1;
                    sel   = PORT_BOOT;
                end else if (rr_any) begin
                    start = 1'b1;
                    sel   = rr_pick ? PORT_DMA : PORT_CPU;
                end
                if (start) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rv_ready || expire) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The round-robin pointer only moves on cpu/dma grants.
    assign rr_advance = start && !m0_valid;

    always_comb begin
        case (sel)
            PORT_BOOT: begin
                sel_addr  = m0_addr;
                sel_wdata = m0_wdata;
                sel_wstrb = m0_wstrb;
            end
            PORT_CPU: begin
                sel_addr  = m1_addr;
                sel_wdata = m1_wdata;
                sel_wstrb = m1_wstrb;
            end
            default: begin
                sel_addr  = m2_addr;
                sel_wdata = m2_wdata;
                sel_wstrb = m2_wstrb;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rv_valid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            grant_q    <= GRANT_NONE;
            ready_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= '0;
            if (start) begin
                rv_valid_q <= 1'b1;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                wstrb_q    <= sel_wstrb;
                grant_q    <= sel;
            end
            if (state_q == BUSY) begin
                // A response on the expiry edge still counts as success.
                if (rv_ready) begin
                    rv_valid_q <= 1'b0;
                    rdata_q    <= rv_rdata;
                    ready_q    <= port_onehot(grant_q);
                end else if (expire) begin
                    rv_valid_q <= 1'b0;
                    rdata_q    <= TIMEOUT_RDATA;
                    ready_q    <= port_onehot(grant_q);
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_err_q;

    // cnt_q counts BUSY cycles already spent; expiry on the TIMEOUT-th one.
    assign expire = (state_q == BUSY) && !rv_ready &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (start) begin
                cnt_q <= '0;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (expire) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign rv_valid = rv_valid_q;
    assign rv_addr  = addr_q;
    assign rv_wdata = wdata_q;
    assign rv_wstrb = wstrb_q;
    assign grant    = grant_q;
    assign m0_ready = ready_q[0];
    assign m1_ready = ready_q[1];
    assign m2_ready = ready_q[2];
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;
    assign m2_rdata = rdata_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: responder model for the downstream port, a
// completion monitor that checks every mN_ready against an expected queue
// of {port, rdata}, and one task per scenario.
module tb_rv_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid, m2_valid;
    logic [22:0] m0_addr, m1_addr, m2_addr;
    logic [31:0] m0_wdata, m1_wdata, m2_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb, m2_wstrb;
    logic        m0_ready, m1_ready, m2_ready;
    logic [31:0] m0_rdata, m1_rdata, m2_rdata;
    logic        rv_valid;
    logic [22:0] rv_addr;
    logic [31:0] rv_wdata;
    logic [3:0]  rv_wstrb;
    logic        rv_ready;
    logic [31:0] rv_rdata;
    logic [1:0]  grant;
    logic        timeout_err;
    logic [1:0]  state_o;

    int compared;
    int mismatched;
    int cyc;

    // Expected completions: {port[1:0], rdata[31:0]}
    logic [33:0] exp_q[$];

    // Downstream responder controls
    bit          resp_en;
    int          resp_lat;
    bit          resp_fixed_en;
    logic [31:0] resp_fixed;
    int          busy_cnt;

    rv_mem_arbiter #(.ADDR_W(23), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .m2_valid(m2_valid), .m2_addr(m2_addr), .m2_wdata(m2_wdata), .m2_wstrb(m2_wstrb),
        .m2_ready(m2_ready), .m2_rdata(m2_rdata),
        .rv_valid(rv_valid), .rv_addr(rv_addr), .rv_wdata(rv_wdata), .rv_wstrb(rv_wstrb),
        .rv_ready(rv_ready), .rv_rdata(rv_rdata),
        .grant(grant), .timeout_err(timeout_err), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [22:0] a);
        return {9'h0, a} ^ 32'hC3C3_5A5A;
    endfunction

    // ---------------- downstream responder ----------------
    // Raises rv_ready for one cycle after rv_valid has been high resp_lat cycles.
    always @(negedge clk) begin
        if (resp_en) begin
            if (!rv_valid) begin
                rv_ready = 1'b0;
                busy_cnt = 0;
            end else begin
                busy_cnt++;
                if (busy_cnt == resp_lat) begin
                    rv_ready = 1'b1;
                    rv_rdata = resp_fixed_en ? resp_fixed : mem_f(rv_addr);
                end else begin
                    rv_ready = 1'b0;
                end
            end
        end
    end

    // ---------------- completion monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [2:0]  rdy;
        logic [2:0]  exp_oh;
        logic [33:0] e;
        logic [31:0] got_d;
        rdy = {m2_ready, m1_ready, m0_ready};
        if (rdy !== 3'b000) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected_ready: got ready=%b grant=%0d, required no completion", rdy, grant);
            end else begin
                e      = exp_q.pop_front();
                exp_oh = 3'b001 << e[33:32];
                case (e[33:32])
                    2'd0:    got_d = m0_rdata;
                    2'd1:    got_d = m1_rdata;
                    default: got_d = m2_rdata;
                endcase
                if (rdy !== exp_oh || grant !== e[33:32] || got_d !== e[31:0]) begin
                    mismatched++;
                    $display("FAIL sb_completion: got ready=%b grant=%0d rdata=%h, required ready=%b grant=%0d rdata=%h",
                             rdy, grant, got_d, exp_oh, e[33:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m1_valid = 0; m2_valid = 0;
        m0_addr = '0; m1_addr = '0; m2_addr = '0;
        m0_wdata = '0; m1_wdata = '0; m2_wdata = '0;
        m0_wstrb = '0; m1_wstrb = '0; m2_wstrb = '0;
    endtask

    task automatic do_reset();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
        tick();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: got %0d completions outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn   = 0;
        m1_valid = 1;
        tick();
        tick();
        compared++;
        if (rv_valid !== 1'b0) begin mismatched++; $display("FAIL rst_rv_valid: got %b required 0", rv_valid); end
        compared++;
        if (grant !== 2'd3) begin mismatched++; $display("FAIL rst_grant: got %0d required 3", grant); end
        compared++;
        if ({m2_ready, m1_ready, m0_ready} !== 3'b000) begin
            mismatched++; $display("FAIL rst_ready: got %b required 000", {m2_ready, m1_ready, m0_ready});
        end
        compared++;
        if (rv_addr !== 23'h0 || rv_wdata !== 32'h0 || rv_wstrb !== 4'h0) begin
            mismatched++; $display("FAIL rst_cmd: got addr=%h wdata=%h wstrb=%h required zeros", rv_addr, rv_wdata, rv_wstrb);
        end
        compared++;
        if (m0_rdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata: got %h required 0", m0_rdata); end
        compared++;
        if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL rst_timeout_err: got %b required 0", timeout_err); end
        compared++;
        if (state_o !== 2'd0) begin mismatched++; $display("FAIL rst_state: got %0d required 0", state_o); end
        m1_valid = 0;
        resetn   = 1;
        tick();
    endtask

    task automatic test_cpu_read();
        int n;
        resp_lat      = 4;
        resp_fixed_en = 1;
        resp_fixed    = 32'h1234_5678;
        m1_addr  = 23'h000100;
        m1_wstrb = 4'b0000;
        m1_valid = 1;
        exp_q.push_back({2'd1, 32'h1234_5678});
        tick();
        compared++;
        if (rv_valid !== 1'b1 || rv_addr !== 23'h000100 || rv_wstrb !== 4'b0000 || grant !== 2'd1) begin
            mismatched++;
            $display("FAIL cpu_issue: got valid=%b addr=%h wstrb=%b grant=%0d required 1/000100/0000/1",
                     rv_valid, rv_addr, rv_wstrb, grant);
        end
        n = 1;
        tick();
        while (rv_valid === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        compared++;
        if (n !== 4) begin mismatched++; $display("FAIL cpu_valid_cycles: got %0d required 4", n); end
        compared++;
        if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m2_ready !== 1'b0) begin
            mismatched++; $display("FAIL cpu_ready_timing: got %b required 010", {m2_ready, m1_ready, m0_ready});
        end
        compared++;
        if (m0_rdata !== 32'h1234_5678) begin
            mismatched++; $display("FAIL cpu_shared_rdata: got %h required 12345678", m0_rdata);
        end
        m1_valid = 0;
        tick();
        compared++;
        if (m1_ready !== 1'b0) begin mismatched++; $display("FAIL cpu_ready_width: got %b required 0", m1_ready); end
        wait_drain("cpu_read");
        resp_fixed_en = 0;
    endtask

    task automatic test_boot_write();
        int n;
        int bad;
        resp_lat = 3;
        m0_addr  = 23'h3FFFFC;
        m0_wstrb = 4'b1000;
        m0_wdata = 32'hAB00_0000;
        m0_valid = 1;
        exp_q.push_back({2'd0, mem_f(23'h3FFFFC)});
        tick();
        n = 0;
        bad = 0;
        while (rv_valid === 1'b1 && n < 50) begin
            if (rv_addr !== 23'h3FFFFC || rv_wstrb !== 4'b1000 || rv_wdata !== 32'hAB00_0000 || grant !== 2'd0) bad++;
            n++;
            tick();
        end
        compared++;
        if (n !== 3 || bad !== 0) begin
            mismatched++;
            $display("FAIL boot_cmd_stable: got %0d cycles with %0d unstable, required 3 cycles stable", n, bad);
        end
        compared++;
        if (m0_ready !== 1'b1) begin mismatched++; $display("FAIL boot_ready: got %b required 1", m0_ready); end
        // valid still held across the DONE cycle
        tick();
        m0_valid = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rv_valid !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin mismatched++; $display("FAIL boot_no_regrant: got %0d busy cycles required 0", bad); end
        wait_drain("boot_write");
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int cnt;
        int n;
        do_reset();
        resp_lat = 2;
        m1_addr = 23'h000100;
        m2_addr = 23'h000200;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({2'd1, mem_f(23'h000100)});
            exp_q.push_back({2'd2, mem_f(23'h000200)});
        end
        m1_valid = 1;
        m2_valid = 1;
        cnt = 0;
        n = 0;
        while (cnt < 4 && n < 200) begin
            tick();
            n++;
            if (m1_ready === 1'b1 || m2_ready === 1'b1) cnt++;
        end
        m1_valid = 0;
        m2_valid = 0;
        compared++;
        if (cnt !== 4) begin mismatched++; $display("FAIL rr_count: got %0d completions required 4", cnt); end
        wait_drain("round_robin");
    endtask

    task automatic test_boot_preempt();
        int  cnt;
        int  n;
        bit  raised;
        do_reset();
        resp_lat = 2;
        m0_addr  = 23'h000040;
        m0_wstrb = 4'b0000;
        m1_addr  = 23'h000100;
        m2_addr  = 23'h000200;
        exp_q.push_back({2'd1, mem_f(23'h000100)});
        exp_q.push_back({2'd2, mem_f(23'h000200)});
        exp_q.push_back({2'd0, mem_f(23'h000040)});
        exp_q.push_back({2'd1, mem_f(23'h000100)});
        exp_q.push_back({2'd2, mem_f(23'h000200)});
        m1_valid = 1;
        m2_valid = 1;
        cnt = 0;
        n = 0;
        raised = 0;
        while (cnt < 5 && n < 200) begin
            tick();
            n++;
            if (!raised && rv_valid === 1'b1 && grant === 2'd2) begin
                m0_valid = 1;
                raised = 1;
            end
            if (m0_ready === 1'b1) m0_valid = 0;
            if (m0_ready === 1'b1 || m1_ready === 1'b1 || m2_ready === 1'b1) cnt++;
        end
        idle_inputs();
        compared++;
        if (cnt !== 5 || !raised) begin
            mismatched++; $display("FAIL preempt_count: got %0d completions raised=%0d required 5 raised=1", cnt, raised);
        end
        wait_drain("boot_preempt");
    endtask

    task automatic test_back_to_back();
        int t[3];
        int cnt;
        int n;
        do_reset();
        resp_lat = 1;
        m2_addr  = 23'h000200;
        for (int i = 0; i < 3; i++) exp_q.push_back({2'd2, mem_f(23'h000200)});
        m2_valid = 1;
        cnt = 0;
        n = 0;
        while (cnt < 3 && n < 100) begin
            tick();
            n++;
            if (m2_ready === 1'b1) begin
                t[cnt] = cyc;
                cnt++;
            end
        end
        m2_valid = 0;
        compared++;
        if (cnt !== 3 || (t[1] - t[0]) !== 3 || (t[2] - t[1]) !== 3) begin
            mismatched++;
            $display("FAIL b2b_turnaround: got %0d completions gaps %0d/%0d required 3 completions gaps 3/3",
                     cnt, t[1] - t[0], t[2] - t[1]);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        int n;
        int hold;
        int bad;
        do_reset();
        resp_en  = 0;
        rv_ready = 0;
        m2_addr  = 23'h000200;
        m2_valid = 1;
        n = 0;
        while (rv_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        hold = 4;
`else
        hold = 20;
`endif
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (rv_valid !== 1'b1) bad++;
            tick();
        end
        compared++;
        if (bad !== 0) begin mismatched++; $display("FAIL mid_busy_hold: got %0d idle cycles required 0", bad); end
        resetn = 0;
        tick();
        compared++;
        if (rv_valid !== 1'b0 || grant !== 2'd3 || {m2_ready, m1_ready, m0_ready} !== 3'b000) begin
            mismatched++;
            $display("FAIL mid_reset: got valid=%b grant=%0d ready=%b required 0/3/000",
                     rv_valid, grant, {m2_ready, m1_ready, m0_ready});
        end
        m2_valid = 0;
        resetn   = 1;
        tick();
        rv_ready = 1;
        rv_rdata = 32'h5555_AAAA;
        tick();
        rv_ready = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rv_valid !== 1'b0 || {m2_ready, m1_ready, m0_ready} !== 3'b000 || grant !== 2'd3) bad++;
        end
        compared++;
        if (bad !== 0) begin mismatched++; $display("FAIL stray_rv_ready: got %0d disturbed cycles required 0", bad); end
        compared++;
        if (m0_rdata !== 32'h0) begin mismatched++; $display("FAIL stray_rdata: got %h required 0", m0_rdata); end
        resp_en = 1;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        resp_en  = 0;
        rv_ready = 0;
        m1_addr  = 23'h000300;
        m1_valid = 1;
        exp_q.push_back({2'd1, 32'hDEAD_BEEF});
        tick();
        n = 0;
        while (rv_valid === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        compared++;
        if (n !== 8) begin mismatched++; $display("FAIL to_valid_cycles: got %0d required 8", n); end
        compared++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'hDEAD_BEEF || timeout_err !== 1'b1) begin
            mismatched++;
            $display("FAIL to_completion: got ready=%b rdata=%h err=%b required 1/deadbeef/1", m1_ready, m1_rdata, timeout_err);
        end
        m1_valid = 0;
        wait_drain("timeout");
        resp_en  = 1;
        resp_lat = 2;
        m1_valid = 1;
        exp_q.push_back({2'd1, mem_f(23'h000300)});
        n = 0;
        while (m1_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        m1_valid = 0;
        wait_drain("timeout_recover");
        compared++;
        if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
        do_reset();
        compared++;
        if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL to_clear: got %b required 0", timeout_err); end
    endtask
`endif

    // ---------------- main sequence / report ----------------
    initial begin
        compared      = 0;
        mismatched    = 0;
        cyc           = 0;
        busy_cnt      = 0;
        resp_en       = 1;
        resp_lat      = 1;
        resp_fixed_en = 0;
        resp_fixed    = '0;
        rv_ready      = 0;
        rv_rdata      = '0;
        resetn        = 0;
        idle_inputs();

        test_reset();
        test_cpu_read();
        test_boot_write();
        test_round_robin();
        test_boot_preempt();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Three-port arbiter that shares the 32-bit RV memory port (SDRAM/BSRAM, 8 MB window) among the flash boot loader, the picorv32 core and a DMA requester (savestate/ROM mover). It sits in iosys between the requesters and the external rv_* port, and replaces the ad-hoc flash_loading mux. Boot port has absolute priority; CPU and DMA share the remaining bandwidth round-robin. Exactly one transaction is outstanding downstream at any time.

## Interface
Parameters:
- ADDR_W, 23, address width of every port
- TIMEOUT, 1023, max cycles to wait for rv_ready (used only with MEM_ARB_TIMEOUT_EN)

Ports (N = 0 boot, 1 cpu, 2 dma):
- clk  in  1  system clock; one clock domain only
- resetn  in  1  reset, synchronous, active-low
- mN_valid  in  1  request; held high until mN_ready is seen
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  32  write data
- mN_wstrb  in  4  byte strobes; 0 = read
- mN_ready  out  1  one-cycle completion pulse
- mN_rdata  out  32  read data, valid while mN_ready=1
- rv_valid  out  1  downstream request
- rv_addr  out  ADDR_W  downstream address
- rv_wdata  out  32  downstream write data
- rv_wstrb  out  4  downstream strobes
- rv_ready  in  1  downstream completion pulse
- rv_rdata  in  32  downstream read data, valid with rv_ready
- grant  out  2  index of current/last granted port (3 = none since reset)
- timeout_err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if m0_valid, grant 0. Else if m1_valid and m2_valid, grant the port not served last (rr pointer, reset value favours 1). Else grant whichever is valid. None valid: stay.
- On grant: latch addr/wdata/wstrb into output registers, set grant, go BUSY; rr pointer updates only on grants to 1 or 2.
- BUSY: rv_valid=1, outputs stable. On rv_ready: capture rv_rdata, drop rv_valid, go DONE.
- DONE: assert mN_ready for the granted port only, for one cycle; go IDLE. Requester's valid is not sampled in DONE, so a request still high from the completed transfer is never regranted.
- rv_ready in IDLE or DONE: ignored.
- Requester dropping valid while BUSY: downstream transfer completes, ready pulse still issued.
- All mN_rdata share one capture register; it holds until the next capture.

## Timing
- Reset values: rv_valid 0, all mN_ready 0, rv_addr/rv_wdata/rv_wstrb 0, rdata register 0, grant 3, timeout_err 0, state IDLE.
- Request seen in IDLE at edge T -> rv_valid high from T+1. rv_ready at cycle R -> mN_ready at R+1 -> next grant earliest at R+2.
- Minimum turnaround: 3 cycles per transaction (rv_ready returned the cycle after rv_valid).
- Simultaneous m0/m1/m2 requests: order 0, then 1 and 2 alternating; boot preempts only between transactions, never mid-transfer.
- Reset mid-transaction: rv_valid low on the next edge, no mN_ready issued; downstream must tolerate an abandoned request.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: a cycle counter runs in BUSY. After TIMEOUT cycles without rv_ready: drop rv_valid, load rdata register with 32'hDEAD_BEEF, set timeout_err (sticky until reset), go DONE with normal ready pulse. rv_ready arriving on the same edge as expiry counts as success.
- Not defined: BUSY waits indefinitely, no counter logic, timeout_err tied 0.

## Structure
- Shared package iosys_pkg: port index constants PORT_BOOT=0, PORT_CPU=1, PORT_DMA=2, GRANT_NONE=3, state enum (IDLE/BUSY/DONE), TIMEOUT_RDATA=32'hDEAD_BEEF.
- One sub-module: arb_rr2, a 2-way round-robin picker (req[1:0], advance, outputs pick and any).

## Test plan
- Single CPU read addr 0x000100, rv_ready after 4 cycles, rv_rdata 0x12345678 -> rv_valid for 4 cycles, m1_ready one cycle later with m1_rdata 0x12345678, grant=1.
- m1 and m2 both held valid for 4 transfers -> grant sequence 1,2,1,2. Raise m0 during the 2nd transfer -> it completes, then 0, then rr resumes.
- Boot write addr 0x3FFFFC, wstrb 4'b1000, wdata 0xAB000000 -> rv_wstrb 4'b1000 and rv_addr stable until rv_ready; the held m0_valid during DONE causes no second transfer.
- resetn low while BUSY -> rv_valid 0 next edge, no mN_ready, grant 3. A stray rv_ready afterwards is ignored.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, rv_ready never returned -> rv_valid drops after 8 cycles, m1_ready with rdata 0xDEADBEEF, timeout_err=1 until reset.
